// File: rtl/counter_pkg.sv
// Shared types for the board counter checker.
//   mon_state_t  : checker FSM states
//   event_code_t : event codes reported on the monitor's event port
package counter_pkg;

  typedef enum logic [1:0] {
    INIT  = 2'b00,
    TRACK = 2'b01,
    FAULT = 2'b10
  } mon_state_t;

  typedef enum logic [1:0] {
    EV_NONE     = 2'b00,
    EV_WRAP     = 2'b01,
    EV_MISMATCH = 2'b10,
    EV_SAT      = 2'b11
  } event_code_t;

endpackage

// File: rtl/counter_monitor_event_slot.sv
// One-entry valid/ready event buffer with a sticky drop flag.
// Ports:
//   clock_i, reset_n_i : clock, asynchronous active-low reset
//   clear_i            : synchronous clear of entry and drop flag
//   raise_i, code_i    : producer offers an event this cycle
//   valid_o, code_o    : held event, code stable until accepted
//   ready_i            : consumer accepts when valid_o && ready_i
//   dropped_o          : sticky, an event arrived while full and not accepted
module event_slot #(
  parameter int unsigned CODE_W = 2
) (
  input  logic              clock_i,
  input  logic              reset_n_i,
  input  logic              clear_i,
  input  logic              raise_i,
  input  logic [CODE_W-1:0] code_i,
  input  logic              ready_i,
  output logic              valid_o,
  output logic [CODE_W-1:0] code_o,
  output logic              dropped_o
);

  always_ff @(posedge clock_i or negedge reset_n_i) begin
    if (!reset_n_i) begin
      valid_o   <= 1'b0;
      code_o    <= '0;
      dropped_o <= 1'b0;
    end else if (clear_i) begin
      valid_o   <= 1'b0;
      code_o    <= '0;
      dropped_o <= 1'b0;
    end else begin
      // An acceptance on the same edge frees the entry for the new event.
      if (raise_i && (!valid_o || ready_i)) begin
        valid_o <= 1'b1;
        code_o  <= code_i;
      end else if (valid_o && ready_i) begin
        valid_o <= 1'b0;
      end
      if (raise_i && valid_o && !ready_i) begin
        dropped_o <= 1'b1;
      end
    end
  end

endmodule

// File: rtl/counter_monitor.sv
// Checker for the enable-gated board counter. Verifies each step is +1
// (mod 2^WIDTH) when the previous enable was high, or a hold otherwise,
// counts wrap-arounds (saturating) and reports WRAP/MISMATCH/SATURATE events.
// Ports:
//   clock_i, reset_n_i : clock, asynchronous active-low reset
//   counter_value_i    : registered counter value under check
//   enable_i           : enable seen by the counter
//   clear_i            : synchronous clear of flags, count, slot; FSM -> INIT
//   wrap_count_o       : wraps seen, saturates at all-ones
//   error_o            : sticky mismatch flag
//   dropped_o          : sticky lost-event flag
//   event_valid_o/event_code_o/event_ready_i : event port
module counter_monitor
  import counter_pkg::*;
#(
  parameter int unsigned WIDTH      = 4,
  parameter int unsigned WRAP_CNT_W = 8
) (
  input  logic                  clock_i,
  input  logic                  reset_n_i,
  input  logic [WIDTH-1:0]      counter_value_i,
  input  logic                  enable_i,
  input  logic                  clear_i,
  output logic [WRAP_CNT_W-1:0] wrap_count_o,
  output logic                  error_o,
  output logic                  dropped_o,
  output logic                  event_valid_o,
  output logic [1:0]            event_code_o,
  input  logic                  event_ready_i
);

  localparam logic [WRAP_CNT_W-1:0] WRAP_MAX     = '1;
  localparam logic [WRAP_CNT_W-1:0] WRAP_PRE_SAT = WRAP_MAX - WRAP_CNT_W'(1);

  mon_state_t       state;
  logic [WIDTH-1:0] prev_val;
  logic             prev_en;
  logic [WIDTH-1:0] exp_val;
  logic             match;
  logic             wrap_seen;
  logic             raise;
  event_code_t      raise_code;

  always_comb begin
    exp_val    = prev_en ? prev_val + WIDTH'(1) : prev_val;
    match      = (counter_value_i == exp_val);
    wrap_seen  = prev_en && (prev_val == '1) && (counter_value_i == '0);
    raise      = 1'b0;
    raise_code = EV_NONE;
    if (!clear_i && state == TRACK) begin
      if (!match) begin
        raise      = 1'b1;
        raise_code = EV_MISMATCH;
      end else if (wrap_seen && wrap_count_o == WRAP_PRE_SAT) begin
        raise      = 1'b1;
        raise_code = EV_SAT;
      end else if (wrap_seen && wrap_count_o != WRAP_MAX) begin
        raise      = 1'b1;
        raise_code = EV_WRAP;
      end
    end
  end

  always_ff @(posedge clock_i or negedge reset_n_i) begin
    if (!reset_n_i) begin
      state        <= INIT;
      prev_val     <= '0;
      prev_en      <= 1'b0;
      wrap_count_o <= '0;
      error_o      <= 1'b0;
    end else begin
      // Sample registers run every edge, including during clear, so INIT
      // only needs one edge to have a valid reference.
      prev_val <= counter_value_i;
      prev_en  <= enable_i;
      if (clear_i) begin
        state        <= INIT;
        wrap_count_o <= '0;
        error_o      <= 1'b0;
      end else begin
        case (state)
          INIT: state <= TRACK;
          TRACK: begin
            if (!match) begin
              error_o <= 1'b1;
              state   <= FAULT;
            end else if (wrap_seen && wrap_count_o != WRAP_MAX) begin
              wrap_count_o <= wrap_count_o + WRAP_CNT_W'(1);
            end
          end
          FAULT: if (match) state <= TRACK;
          default: state <= INIT;
        endcase
      end
    end
  end

  event_slot #(
    .CODE_W (2)
  ) u_event_slot (
    .clock_i   (clock_i),
    .reset_n_i (reset_n_i),
    .clear_i   (clear_i),
    .raise_i   (raise),
    .code_i    (raise_code),
    .ready_i   (event_ready_i),
    .valid_o   (event_valid_o),
    .code_o    (event_code_o),
    .dropped_o (dropped_o)
  );

endmodule

// File: tb/tb_counter_monitor.sv
module tb_counter_monitor;
  import counter_pkg::*;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic [3:0] cval = '0;
  logic       en = 1'b0;
  logic       clr1 = 1'b0;
  logic       clr2 = 1'b1;
  logic       ready = 1'b1;

  logic [7:0] wc1;
  logic       err1, drop1, v1;
  logic [1:0] code1;
  logic [1:0] wc2;
  logic       err2, drop2, v2;
  logic [1:0] code2;

  logic [1:0] q1[$];
  logic [1:0] q2[$];
  logic [1:0] exp_code;
  logic [3:0] cnt;
  int n_cmp = 0;
  int n_bad = 0;

  always #5 clk = ~clk;

  counter_monitor #(.WIDTH(4), .WRAP_CNT_W(8)) u_dut (
    .clock_i(clk), .reset_n_i(rst_n), .counter_value_i(cval), .enable_i(en),
    .clear_i(clr1), .wrap_count_o(wc1), .error_o(err1), .dropped_o(drop1),
    .event_valid_o(v1), .event_code_o(code1), .event_ready_i(ready)
  );

  counter_monitor #(.WIDTH(4), .WRAP_CNT_W(2)) u_dut2 (
    .clock_i(clk), .reset_n_i(rst_n), .counter_value_i(cval), .enable_i(en),
    .clear_i(clr2), .wrap_count_o(wc2), .error_o(err2), .dropped_o(drop2),
    .event_valid_o(v2), .event_code_o(code2), .event_ready_i(ready)
  );

  initial begin
    #200000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1);
  end

  // Drive one sample; acceptances seen before the edge are scored against the queues.
  task automatic step(input logic [3:0] v, input logic e);
    cval = v;
    en   = e;
    @(negedge clk);
    if (rst_n && v1 && ready) begin
      n_cmp++;
      if (q1.size() == 0) begin
        n_bad++; $display("FAIL ev1_unexpected got=%0h exp=none", code1);
      end else begin
        exp_code = q1.pop_front();
        if (code1 !== exp_code) begin n_bad++; $display("FAIL ev1_code got=%0h exp=%0h", code1, exp_code); end
      end
    end
    if (rst_n && v2 && ready) begin
      n_cmp++;
      if (q2.size() == 0) begin
        n_bad++; $display("FAIL ev2_unexpected got=%0h exp=none", code2);
      end else begin
        exp_code = q2.pop_front();
        if (code2 !== exp_code) begin n_bad++; $display("FAIL ev2_code got=%0h exp=%0h", code2, exp_code); end
      end
    end
    @(posedge clk);
    #1;
  endtask

  task automatic run_count(input int unsigned n);
    for (int unsigned i = 0; i < n; i++) begin
      step(cnt, 1'b1);
      cnt = cnt + 4'd1;
    end
  endtask

  task automatic clear1_pulse();
    clr1 = 1'b1;
    step(4'd0, 1'b0);
    clr1 = 1'b0;
  endtask

  task automatic test_reset();
    rst_n = 1'b0; cval = '0; en = 1'b0; clr1 = 1'b0; clr2 = 1'b1; ready = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    n_cmp++; if (wc1 !== 8'd0) begin n_bad++; $display("FAIL rst_wrap got=%0d exp=0", wc1); end
    n_cmp++; if (err1 !== 1'b0) begin n_bad++; $display("FAIL rst_error got=%0b exp=0", err1); end
    n_cmp++; if (drop1 !== 1'b0) begin n_bad++; $display("FAIL rst_dropped got=%0b exp=0", drop1); end
    n_cmp++; if (v1 !== 1'b0) begin n_bad++; $display("FAIL rst_valid got=%0b exp=0", v1); end
    n_cmp++; if (u_dut.state !== INIT) begin n_bad++; $display("FAIL rst_state got=%0d exp=%0d", u_dut.state, INIT); end
    rst_n = 1'b1;
    cnt = '0;
  endtask

  task automatic test_count_wrap();
    cnt = '0;
    q1.push_back(EV_WRAP);
    run_count(17);
    n_cmp++; if (wc1 !== 8'd1) begin n_bad++; $display("FAIL wrap_count got=%0d exp=1", wc1); end
    n_cmp++; if (err1 !== 1'b0) begin n_bad++; $display("FAIL wrap_error got=%0b exp=0", err1); end
    n_cmp++; if (v1 !== 1'b1) begin n_bad++; $display("FAIL wrap_latency got=%0b exp=1", v1); end
  endtask

  task automatic test_mismatch();
    clear1_pulse();
    step(4'd0, 1'b1);
    step(4'd1, 1'b0);
    step(4'd1, 1'b1);
    step(4'd2, 1'b1);
    step(4'd3, 1'b1);
    n_cmp++; if (err1 !== 1'b0) begin n_bad++; $display("FAIL hold_error got=%0b exp=0", err1); end
    n_cmp++; if (u_dut.state !== TRACK) begin n_bad++; $display("FAIL hold_state got=%0d exp=%0d", u_dut.state, TRACK); end
    n_cmp++; if (v1 !== 1'b0) begin n_bad++; $display("FAIL hold_valid got=%0b exp=0", v1); end
    q1.push_back(EV_MISMATCH);
    step(4'd5, 1'b1);
    n_cmp++; if (v1 !== 1'b1) begin n_bad++; $display("FAIL mm_valid got=%0b exp=1", v1); end
    n_cmp++; if (code1 !== EV_MISMATCH) begin n_bad++; $display("FAIL mm_code got=%0h exp=%0h", code1, EV_MISMATCH); end
    n_cmp++; if (err1 !== 1'b1) begin n_bad++; $display("FAIL mm_error got=%0b exp=1", err1); end
    n_cmp++; if (u_dut.state !== FAULT) begin n_bad++; $display("FAIL mm_state got=%0d exp=%0d", u_dut.state, FAULT); end
  endtask

  task automatic test_resync();
    step(4'd9, 1'b1);
    n_cmp++; if (u_dut.state !== FAULT) begin n_bad++; $display("FAIL fault_stay got=%0d exp=%0d", u_dut.state, FAULT); end
    n_cmp++; if (v1 !== 1'b0) begin n_bad++; $display("FAIL fault_noevent got=%0b exp=0", v1); end
    step(4'd10, 1'b1);
    n_cmp++; if (u_dut.state !== TRACK) begin n_bad++; $display("FAIL resync_state got=%0d exp=%0d", u_dut.state, TRACK); end
    n_cmp++; if (err1 !== 1'b1) begin n_bad++; $display("FAIL resync_sticky got=%0b exp=1", err1); end
    cnt = 4'd11;
    q1.push_back(EV_WRAP);
    run_count(6);
    n_cmp++; if (wc1 !== 8'd1) begin n_bad++; $display("FAIL resync_wrap got=%0d exp=1", wc1); end
    n_cmp++; if (code1 !== EV_WRAP) begin n_bad++; $display("FAIL resync_code got=%0h exp=%0h", code1, EV_WRAP); end
  endtask

  task automatic test_saturate();
    clr1 = 1'b1;
    clr2 = 1'b0;
    cnt = '0;
    q2.push_back(EV_WRAP);
    q2.push_back(EV_WRAP);
    q2.push_back(EV_SAT);
    run_count(17);
    n_cmp++; if (wc2 !== 2'd1) begin n_bad++; $display("FAIL sat_w1 got=%0d exp=1", wc2); end
    run_count(16);
    n_cmp++; if (wc2 !== 2'd2) begin n_bad++; $display("FAIL sat_w2 got=%0d exp=2", wc2); end
    run_count(16);
    n_cmp++; if (wc2 !== 2'd3) begin n_bad++; $display("FAIL sat_w3 got=%0d exp=3", wc2); end
    n_cmp++; if (code2 !== EV_SAT) begin n_bad++; $display("FAIL sat_code got=%0h exp=%0h", code2, EV_SAT); end
    run_count(16);
    n_cmp++; if (wc2 !== 2'd3) begin n_bad++; $display("FAIL sat_hold got=%0d exp=3", wc2); end
    n_cmp++; if (v2 !== 1'b0) begin n_bad++; $display("FAIL sat_noevent got=%0b exp=0", v2); end
    clr2 = 1'b1;
  endtask

  task automatic test_back_to_back();
    clr1 = 1'b0;
    ready = 1'b0;
    cnt = '0;
    q1.push_back(EV_WRAP);
    run_count(33);
    n_cmp++; if (v1 !== 1'b1) begin n_bad++; $display("FAIL drop_valid got=%0b exp=1", v1); end
    n_cmp++; if (code1 !== EV_WRAP) begin n_bad++; $display("FAIL drop_code got=%0h exp=%0h", code1, EV_WRAP); end
    n_cmp++; if (drop1 !== 1'b1) begin n_bad++; $display("FAIL drop_flag got=%0b exp=1", drop1); end
    ready = 1'b1;
    run_count(1);
    clear1_pulse();
    n_cmp++; if (drop1 !== 1'b0) begin n_bad++; $display("FAIL clr_drop got=%0b exp=0", drop1); end
    ready = 1'b0;
    cnt = '0;
    q1.push_back(EV_WRAP);
    q1.push_back(EV_WRAP);
    run_count(32);
    ready = 1'b1;
    run_count(1);
    n_cmp++; if (drop1 !== 1'b0) begin n_bad++; $display("FAIL reload_drop got=%0b exp=0", drop1); end
    n_cmp++; if (v1 !== 1'b1) begin n_bad++; $display("FAIL reload_valid got=%0b exp=1", v1); end
    n_cmp++; if (wc1 !== 8'd2) begin n_bad++; $display("FAIL reload_count got=%0d exp=2", wc1); end
    run_count(1);
  endtask

  task automatic test_reset_clear();
    clear1_pulse();
    ready = 1'b0;
    cnt = '0;
    run_count(17);
    n_cmp++; if (v1 !== 1'b1) begin n_bad++; $display("FAIL pend_valid got=%0b exp=1", v1); end
    #2;
    rst_n = 1'b0;
    #1;
    n_cmp++; if (wc1 !== 8'd0) begin n_bad++; $display("FAIL arst_wrap got=%0d exp=0", wc1); end
    n_cmp++; if (v1 !== 1'b0) begin n_bad++; $display("FAIL arst_valid got=%0b exp=0", v1); end
    n_cmp++; if (code1 !== 2'd0) begin n_bad++; $display("FAIL arst_code got=%0h exp=0", code1); end
    n_cmp++; if (err1 !== 1'b0 || drop1 !== 1'b0) begin n_bad++; $display("FAIL arst_flags got=%0b%0b exp=00", err1, drop1); end
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    ready = 1'b1;
    cnt = '0;
    q1.push_back(EV_WRAP);
    run_count(17);
    q1.push_back(EV_MISMATCH);
    step(4'd5, 1'b1);
    n_cmp++; if (err1 !== 1'b1 || wc1 !== 8'd1) begin n_bad++; $display("FAIL preclr got=%0b/%0d exp=1/1", err1, wc1); end
    clear1_pulse();
    n_cmp++; if (wc1 !== 8'd0) begin n_bad++; $display("FAIL clr_wrap got=%0d exp=0", wc1); end
    n_cmp++; if (err1 !== 1'b0) begin n_bad++; $display("FAIL clr_error got=%0b exp=0", err1); end
    n_cmp++; if (v1 !== 1'b0) begin n_bad++; $display("FAIL clr_valid got=%0b exp=0", v1); end
    n_cmp++; if (u_dut.state !== INIT) begin n_bad++; $display("FAIL clr_state got=%0d exp=%0d", u_dut.state, INIT); end
  endtask

  initial begin
    test_reset();
    test_count_wrap();
    test_mismatch();
    test_resync();
    test_saturate();
    test_back_to_back();
    test_reset_clear();
    repeat (3) step(4'd0, 1'b0);
    n_cmp++; if (q1.size() != 0) begin n_bad++; $display("FAIL q1_left got=%0d exp=0", q1.size()); end
    n_cmp++; if (q2.size() != 0) begin n_bad++; $display("FAIL q2_left got=%0d exp=0", q2.size()); end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
